fetch_unit: RTL and testbench

- Parametrised successor to the single-cycle PC/mux/instruction-memory fetch path.
- Holds a fetch PC and issues instruction reads to the OTTER memory port 1, which has a fixed 1-cycle synchronous read latency.
- Buffers returned instructions, each with its PC, in a DEPTH-entry prefetch FIFO drained by a valid/ready handshake.
- On redirect (JALR, branch, jump or restart) it flushes the FIFO and squashes the in-flight read.

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Prefetching instruction fetch unit: issues reads on a 1-cycle synchronous memory port
// and buffers {instruction, PC} pairs in a DEPTH-entry FIFO, flushed on redirect.
module fetch_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned INC = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic                       REDIRECT,
    input  logic [1:0]                 PC_SOURCE,
    input  logic [XLEN-1:0]            JALR,
    input  logic [XLEN-1:0]            BRANCH,
    input  logic [XLEN-1:0]            JUMP,
    output logic [XLEN-1:0]            MEM_ADDR1,
    output logic                       MEM_READ1,
    input  logic [XLEN-1:0]            MEM_DOUT1,
    output logic                       IR_VALID,
    input  logic                       IR_READY,
    output logic [XLEN-1:0]            IR,
    output logic [XLEN-1:0]            IR_PC,
    output logic [$clog2(DEPTH):0]     OCCUPANCY
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] issued_pc_q;
    logic            inflight_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic [XLEN-1:0] ir_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];

    logic [XLEN-1:0] target;
    logic            deq;
    logic            wr_en;
    logic            issue;
    logic [CW:0]     level;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        target = RESET_VEC;
        case (PC_SOURCE)
            2'd1:    target = JALR;
            2'd2:    target = BRANCH;
            2'd3:    target = JUMP;
            default: target = RESET_VEC;
        endcase
    end

    assign IR_VALID  = (count_q != '0);
    assign deq       = IR_VALID && IR_READY;
    // Entries committed after this edge; a dequeue this cycle frees a slot for a new read.
    assign level     = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(deq);
    assign issue     = RESET_N && !REDIRECT && (level < DEPTH_L);
    // A redirect squashes the read issued last cycle: its data is dropped here.
    assign wr_en     = inflight_q && !REDIRECT;

    assign MEM_ADDR1 = pc_q;
    assign MEM_READ1 = issue;
    assign IR        = ir_mem[rd_ptr_q];
    assign IR_PC     = pc_mem[rd_ptr_q];
    assign OCCUPANCY = count_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q        <= RESET_VEC;
            issued_pc_q <= RESET_VEC;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else if (REDIRECT) begin
            pc_q       <= target;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                issued_pc_q <= pc_q;
                pc_q        <= pc_q + XLEN'(INC);
            end
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq)   rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(wr_en) - CW'(deq);
        end
    end

    // NOTE: FIFO storage is not reset; count_q gates validity, so stale contents are never observed.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            ir_mem[wr_ptr_q] <= MEM_DOUT1;
            pc_mem[wr_ptr_q] <= issued_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [1:0]  PC_SOURCE = 2'd0;
    logic [31:0] JALR = '0, BRANCH = '0, JUMP = '0;
    logic [31:0] MEM_ADDR1;
    logic        MEM_READ1;
    logic [31:0] MEM_DOUT1 = '0;
    logic        IR_VALID;
    logic        IR_READY = 1'b0;
    logic [31:0] IR, IR_PC;
    logic [2:0]  OCCUPANCY;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .INC(4), .RESET_VEC(32'h0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REDIRECT(REDIRECT), .PC_SOURCE(PC_SOURCE),
        .JALR(JALR), .BRANCH(BRANCH), .JUMP(JUMP),
        .MEM_ADDR1(MEM_ADDR1), .MEM_READ1(MEM_READ1), .MEM_DOUT1(MEM_DOUT1),
        .IR_VALID(IR_VALID), .IR_READY(IR_READY), .IR(IR), .IR_PC(IR_PC),
        .OCCUPANCY(OCCUPANCY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    // Memory stub: 1-cycle synchronous read.
    always @(posedge CLK) if (MEM_READ1) MEM_DOUT1 <= word(MEM_ADDR1);

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    bit          m_inf;
    logic [31:0] m_ipc;
    bit          exp_deq, exp_rd;
    int          n_checks = 0;
    int          n_errors = 0;
    int          issues;
    bit          saw40;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc  = 32'h0;
        m_inf = 0;
        m_ipc = 32'h0;
    endtask

    // Called at a falling edge after inputs are driven: compare DUT against the model.
    task automatic sample();
        #1;
        exp_deq = (m_q.size() > 0) && IR_READY;
        exp_rd  = !REDIRECT && ((m_q.size() + int'(m_inf) - int'(exp_deq)) < DEPTH);
        check("ir_valid", 32'(IR_VALID), 32'(m_q.size() > 0));
        check("occupancy", 32'(OCCUPANCY), 32'(m_q.size()));
        check("mem_read1", 32'(MEM_READ1), 32'(exp_rd));
        check("mem_addr1", MEM_ADDR1, m_pc);
        if (m_q.size() > 0) begin
            check("ir", IR, m_q[0].ir);
            check("ir_pc", IR_PC, m_q[0].pc);
        end
        if (MEM_READ1) issues++;
        if (IR_VALID && IR_PC == 32'h40) saw40 = 1;
    endtask

    // Advance the model across the rising edge, return at the next falling edge.
    task automatic tick();
        @(posedge CLK);
        if (REDIRECT) begin
            m_q.delete();
            m_inf = 0;
            case (PC_SOURCE)
                2'd0: m_pc = 32'h0;
                2'd1: m_pc = JALR;
                2'd2: m_pc = BRANCH;
                default: m_pc = JUMP;
            endcase
        end else begin
            if (exp_deq) void'(m_q.pop_front());
            if (m_inf) m_q.push_back('{ir: word(m_ipc), pc: m_ipc});
            m_inf = exp_rd;
            if (exp_rd) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
        end
        @(negedge CLK);
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        REDIRECT = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic redirect_once(input logic [1:0] src);
        REDIRECT  = 1'b1;
        PC_SOURCE = src;
        cycle();
        REDIRECT  = 1'b0;
    endtask

    initial begin
        // Reset release with consumer ready: streaming from RESET_VEC.
        IR_READY = 1'b1;
        do_reset();
        sample();
        check("first_read", 32'(MEM_READ1), 32'd1);
        check("first_addr", MEM_ADDR1, 32'h0);
        tick();
        sample();
        check("valid_after_1", 32'(IR_VALID), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            sample();
            check("stream_pc", IR_PC, 32'(4 * k));
            check("stream_ir", IR, 32'h1000 + 32'(k));
            tick();
        end

        // Branch redirect during streaming.
        BRANCH = 32'h200;
        redirect_once(2'd2);
        sample();
        check("br_occ", 32'(OCCUPANCY), 32'd0);
        check("br_addr", MEM_ADDR1, 32'h200);
        check("br_read", 32'(MEM_READ1), 32'd1);
        tick();
        sample();
        check("br_squash", 32'(IR_VALID), 32'd0);
        tick();
        sample();
        check("br_pc0", IR_PC, 32'h200);
        tick();
        sample();
        check("br_pc1", IR_PC, 32'h204);
        tick();

        // Back-to-back redirects: JALR then JUMP, the second wins.
        JALR = 32'h40;
        JUMP = 32'h80;
        redirect_once(2'd1);
        REDIRECT = 1'b1;
        PC_SOURCE = 2'd3;
        sample();
        check("b2b_no_issue", 32'(MEM_READ1), 32'd0);
        tick();
        REDIRECT = 1'b0;
        saw40 = 0;
        sample();
        check("b2b_addr", MEM_ADDR1, 32'h80);
        check("b2b_read", 32'(MEM_READ1), 32'd1);
        tick();
        cycle();
        sample();
        check("b2b_pc", IR_PC, 32'h80);
        tick();
        repeat (8) cycle();
        check("b2b_no_40", 32'(saw40), 32'd0);

        // PC wrap at 2^32.
        JUMP = 32'hFFFF_FFF8;
        redirect_once(2'd3);
        cycle();
        cycle();
        sample();
        check("wrap_pc0", IR_PC, 32'hFFFF_FFF8);
        tick();
        sample();
        check("wrap_pc1", IR_PC, 32'hFFFF_FFFC);
        tick();
        sample();
        check("wrap_pc2", IR_PC, 32'h0);
        check("wrap_ir2", IR, 32'h1000);
        tick();

        // Consumer stalled: FIFO fills to DEPTH, then drains one issue per dequeue.
        IR_READY = 1'b0;
        do_reset();
        issues = 0;
        repeat (8) cycle();
        check("fill_issues", 32'(issues), 32'(DEPTH));
        sample();
        check("fill_occ", 32'(OCCUPANCY), 32'(DEPTH));
        check("fill_no_read", 32'(MEM_READ1), 32'd0);
        tick();
        IR_READY = 1'b1;
        sample();
        check("full_deq_issue", 32'(MEM_READ1), 32'd1);
        tick();
        repeat (20) cycle();

        // Asynchronous reset with three entries buffered.
        IR_READY = 1'b0;
        redirect_once(2'd0);
        for (int n = 0; n < 20 && m_q.size() != 3; n++) cycle();
        check("reach_occ3", 32'(m_q.size()), 32'd3);
        #3;
        RESET_N = 1'b0;
        #1;
        check("arst_valid", 32'(IR_VALID), 32'd0);
        check("arst_occ", 32'(OCCUPANCY), 32'd0);
        check("arst_read", 32'(MEM_READ1), 32'd0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        sample();
        check("arst_restart_addr", MEM_ADDR1, 32'h0);
        check("arst_restart_read", 32'(MEM_READ1), 32'd1);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            IR_READY  = ($urandom_range(0, 9) < 7);
            REDIRECT  = ($urandom_range(0, 19) == 0);
            PC_SOURCE = 2'($urandom_range(0, 3));
            JALR      = $urandom;
            BRANCH    = $urandom & 32'hFFFF_FFFC;
            JUMP      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            cycle();
        end
        REDIRECT = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
